// File: rtl/bp_be_dcache_port_arbiter.sv
// bp_be_dcache_port_arbiter: shares the single D$ request port between the PTW and the memory pipe
//   clk_i, reset_n_i (sync, active-low), flush_i (drop pipe ownership in flight)
//   ptw_*  : PTW request (v/pkt/grant), stage-1 tag (ptag/ptag_v), stage-2 response (early_v/data)
//   pipe_* : pipe request (v/pkt/grant), stage-1 tag (ptag/ptag_v), stage-2 response (early_v/data)
//   dcache_*: request/tag to the D$, early response from the D$
//   Optional macro BP_BE_DCACHE_ARB_STARVE_EN adds a pipe starvation counter (limit starve_limit_p).
module bp_be_dcache_port_arbiter #(
  parameter int pkt_width_p    = 82,
  parameter int ptag_width_p   = 28,
  parameter int dpath_width_p  = 64,
  parameter int starve_limit_p = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     flush_i,
  input  logic                     ptw_v_i,
  input  logic [pkt_width_p-1:0]   ptw_pkt_i,
  output logic                     ptw_grant_o,
  input  logic [ptag_width_p-1:0]  ptw_ptag_i,
  input  logic                     ptw_ptag_v_i,
  output logic                     ptw_early_v_o,
  output logic [dpath_width_p-1:0] ptw_early_data_o,
  input  logic                     pipe_v_i,
  input  logic [pkt_width_p-1:0]   pipe_pkt_i,
  output logic                     pipe_grant_o,
  input  logic [ptag_width_p-1:0]  pipe_ptag_i,
  input  logic                     pipe_ptag_v_i,
  output logic                     pipe_early_v_o,
  output logic [dpath_width_p-1:0] pipe_early_data_o,
  input  logic                     dcache_ready_i,
  output logic                     dcache_v_o,
  output logic [pkt_width_p-1:0]   dcache_pkt_o,
  output logic [ptag_width_p-1:0]  dcache_ptag_o,
  output logic                     dcache_ptag_v_o,
  input  logic                     dcache_early_v_i,
  input  logic [dpath_width_p-1:0] dcache_early_data_i
);
  // owner id: 0 = PTW, 1 = pipe
  logic own1_v_q, own1_id_q, own2_v_q, own2_id_q;
  logic own1_v_d, own1_id_d, own2_v_d, own2_id_d;
  logic starved, pipe_ok;
  assign pipe_ok      = pipe_v_i & ~flush_i;
  // a starved pipe only outranks the PTW when it can actually be granted
  assign ptw_grant_o  = reset_n_i & dcache_ready_i & ptw_v_i & ~(starved & pipe_ok);
  assign pipe_grant_o = reset_n_i & dcache_ready_i & pipe_ok & (~ptw_v_i | starved);
  assign dcache_v_o   = ptw_grant_o | pipe_grant_o;
  assign dcache_pkt_o = pipe_grant_o ? pipe_pkt_i : ptw_pkt_i;
  always_comb begin
    own1_v_d          = dcache_v_o;
    own1_id_d         = pipe_grant_o;
    own2_v_d          = own1_v_q & ~(flush_i & own1_id_q);
    own2_id_d         = own1_id_q;
    dcache_ptag_o     = own1_id_q ? pipe_ptag_i : ptw_ptag_i;
    dcache_ptag_v_o   = reset_n_i & own1_v_q & (own1_id_q ? pipe_ptag_v_i & ~flush_i : ptw_ptag_v_i);
    ptw_early_v_o     = reset_n_i & dcache_early_v_i & own2_v_q & ~own2_id_q;
    pipe_early_v_o    = reset_n_i & dcache_early_v_i & own2_v_q & own2_id_q & ~flush_i;
    ptw_early_data_o  = dcache_early_data_i;
    pipe_early_data_o = dcache_early_data_i;
  end
  always_ff @(posedge clk_i)
    if (!reset_n_i) {own1_v_q, own1_id_q, own2_v_q, own2_id_q} <= '0;
    else {own1_v_q, own1_id_q, own2_v_q, own2_id_q} <= {own1_v_d, own1_id_d, own2_v_d, own2_id_d};
`ifdef BP_BE_DCACHE_ARB_STARVE_EN
  localparam int cw = $clog2(starve_limit_p + 1);
  logic [cw-1:0] cnt_q, cnt_d;
  assign starved = cnt_q == cw'(starve_limit_p);
  // saturates at the limit; a denied pipe at the limit can only be a flushed or reset one
  assign cnt_d = (pipe_grant_o | flush_i) ? '0
               : (pipe_v_i & dcache_ready_i & ~starved) ? cnt_q + cw'(1) : cnt_q;
  always_ff @(posedge clk_i)
    if (!reset_n_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign starved = 1'b0 & (starve_limit_p != 0);
`endif
endmodule
